// File: rtl/axi_slv_wr_resp.sv
// rtl/axi_slv_wr_resp.sv - AXI3 slave write responder with byte-strobed memory
//
// Accepts one write burst at a time (AW, then W beats), writes an internal
// DATA_W-wide memory under byte strobes and returns a B response.
// Ports:
//   aclk, arstn                     clock, synchronous active-low reset
//   awid/awaddr/awlen/awsize/awbrust/awvalid -> awready   write address channel
//   wid/wdata/wstrob/wlast/wvalid   -> wready              write data channel
//   bid/bresp/bvalid                <- bready              write response channel
//   dbg_addr -> dbg_data            combinational backdoor word read
module axi_slv_wr_resp #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int MEM_WORDS = 256,
    localparam int STRB_W   = DATA_W / 8,
    localparam int IDX_W    = $clog2(MEM_WORDS)
) (
    input  logic              aclk,
    input  logic              arstn,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awbrust,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrob,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int          SZ_MAX    = $clog2(STRB_W);
    localparam logic [2:0]  SZ_MAX3   = 3'(SZ_MAX);
    localparam int          MEM_BYTES = MEM_WORDS * STRB_W;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;
    localparam logic [1:0]  RESP_DEC  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_awready, r_wready, r_bvalid;
    logic                w_awready_nxt, w_wready_nxt, w_bvalid_nxt;

    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic [LEN_W-1:0]    r_cnt;
    logic [1:0]          r_err;
    logic                r_sup;
    logic [ID_W-1:0]     r_bid;
    logic [1:0]          r_bresp;
    logic [DATA_W-1:0]   r_mem [MEM_WORDS];

    logic                w_aw_hs, w_w_hs, w_last_beat;
    logic [LEN_W-1:0]    w_len_p1;
    logic                w_wrap_len_ok, w_aw_bad;
    logic                w_oor, w_slv_beat, w_we;
    logic [1:0]          w_err_beat, w_err_nxt;
    logic [ADDR_W-1:0]   w_bytes, w_wrap_bytes, w_lower, w_incr, w_addr_nxt;
    logic [IDX_W-1:0]    w_idx;

    assign awready  = r_awready;
    assign wready   = r_wready;
    assign bvalid   = r_bvalid;
    assign bid      = r_bid;
    assign bresp    = r_bresp;
    assign dbg_data = r_mem[dbg_addr];

    assign w_aw_hs     = awvalid & r_awready;
    assign w_w_hs      = wvalid & r_wready;
    assign w_last_beat = (r_cnt == r_len);

    // WRAP is legal only for 2/4/8/16 beats: awlen+1 must be a power of two > 1
    assign w_len_p1      = awlen + LEN_W'(1);
    assign w_wrap_len_ok = (awlen != '0) && ((awlen & w_len_p1) == '0);
    assign w_aw_bad      = (awsize > SZ_MAX3) || (awbrust == 2'b11) ||
                           ((awbrust == 2'b10) && !w_wrap_len_ok);

    // Per-beat checks; error codes are ordered so a numeric max keeps the worst
    assign w_oor      = (r_addr >= ADDR_W'(MEM_BYTES));
    assign w_slv_beat = (wid != r_id) || (wlast != w_last_beat);
    assign w_err_beat = w_oor ? RESP_DEC : (w_slv_beat ? RESP_SLV : RESP_OKAY);
    assign w_err_nxt  = (w_err_beat > r_err) ? w_err_beat : r_err;

    // Beat address sequencing
    assign w_bytes      = ADDR_W'(1) << r_size;
    assign w_wrap_bytes = (ADDR_W'(r_len) + ADDR_W'(1)) << r_size;
    assign w_lower      = r_addr & ~(w_wrap_bytes - ADDR_W'(1));
    assign w_incr       = r_addr + w_bytes;

    always_comb begin
        w_addr_nxt = r_addr;
        case (r_burst)
            2'b01:   w_addr_nxt = (r_addr & ~(w_bytes - ADDR_W'(1))) + w_bytes;
            2'b10:   w_addr_nxt = (w_incr == w_lower + w_wrap_bytes) ? w_lower : w_incr;
            default: w_addr_nxt = r_addr;
        endcase
    end

    // A beat sampled in the reset cycle must not touch memory
    assign w_we  = w_w_hs & ~r_sup & ~w_oor & arstn;
    assign w_idx = r_addr[SZ_MAX +: IDX_W];

    // State register; ready/valid outputs are registered from the next state
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            r_state   <= S_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_aw_hs) w_state_nxt = S_DATA;
            S_DATA:  if (w_w_hs && w_last_beat) w_state_nxt = S_RESP;
            S_RESP:  if (r_bvalid && bready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_awready_nxt = (w_state_nxt == S_IDLE);
        w_wready_nxt  = (w_state_nxt == S_DATA);
        w_bvalid_nxt  = (w_state_nxt == S_RESP);
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= RESP_OKAY;
            r_sup   <= 1'b0;
            r_bid   <= '0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_id    <= awid;
                r_addr  <= awaddr;
                r_len   <= awlen;
                r_size  <= awsize;
                r_burst <= awbrust;
                r_cnt   <= '0;
                r_err   <= w_aw_bad ? RESP_SLV : RESP_OKAY;
                r_sup   <= w_aw_bad;
            end
            if (w_w_hs) begin
                r_addr <= w_addr_nxt;
                r_cnt  <= r_cnt + LEN_W'(1);
                r_err  <= w_err_nxt;
                if (w_last_beat) begin
                    r_bid   <= r_id;
                    r_bresp <= w_err_nxt;
                end
            end
        end
    end

    // Memory contents survive reset
    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrob[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_slv_wr_resp.sv
// tb/tb_axi_slv_wr_resp.sv - directed self-checking bench for axi_slv_wr_resp
module tb_axi_slv_wr_resp;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awbrust = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrob = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    axi_slv_wr_resp dut (
        .aclk(aclk), .arstn(arstn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awbrust(awbrust), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrob(wstrob), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok = 1'b0;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awbrust = burst; awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (awready) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        chk("aw_handshake", ok, 1);
        @(posedge aclk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input int gap);
        logic ok = 1'b0;
        @(negedge aclk);
        repeat (gap) @(negedge aclk);
        wid = id; wdata = data; wstrob = strb; wlast = last; wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (wready) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        chk("w_handshake", ok, 1);
        @(posedge aclk); #1 wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic get_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        logic ok = 1'b0;
        @(negedge aclk);
        bready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (bvalid) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        chk({tag, "_bvalid"}, ok, 1);
        chk({tag, "_bid"}, bid, exp_id);
        chk({tag, "_bresp"}, bresp, exp_resp);
        @(posedge aclk); #1 bready = 1'b0;
    endtask

    task automatic mem_chk(input string tag, input logic [7:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        @(negedge aclk) arstn = 1'b1;
        @(posedge aclk); #1;
        chk("rel_awready", awready, 1);

        // 1: INCR burst
        send_aw(4'd3, 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(4'd3, 32'hA0 + i, 4'hF, i == 3, 0);
        get_b("incr", 4'd3, 2'b00);
        for (int i = 0; i < 4; i++) mem_chk("incr_mem", 8'(4 + i), 32'hA0 + i);

        // 2: FIXED with partial strobes
        send_aw(4'd2, 32'h20, 4'd1, 3'd2, 2'b00);
        send_w(4'd2, 32'h11223344, 4'h3, 1'b0, 0);
        send_w(4'd2, 32'h55667788, 4'hC, 1'b1, 0);
        get_b("fixed", 4'd2, 2'b00);
        mem_chk("fixed_mem", 8'd8, 32'h55663344);

        // 3: WRAP from 0x38: words 14,15,12,13
        send_aw(4'd1, 32'h38, 4'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) send_w(4'd1, 32'(i + 1), 4'hF, i == 3, 0);
        get_b("wrap", 4'd1, 2'b00);
        mem_chk("wrap_w14", 8'd14, 32'd1);
        mem_chk("wrap_w15", 8'd15, 32'd2);
        mem_chk("wrap_w12", 8'd12, 32'd3);
        mem_chk("wrap_w13", 8'd13, 32'd4);

        // 4: errors; word 0 preloaded as a sentinel
        send_aw(4'd0, 32'h0, 4'd0, 3'd2, 2'b01);
        send_w(4'd0, 32'hCAFEF00D, 4'hF, 1'b1, 0);
        get_b("pre", 4'd0, 2'b00);
        send_aw(4'd0, 32'd1024, 4'd0, 3'd2, 2'b01);
        send_w(4'd0, 32'hDEADBEEF, 4'hF, 1'b1, 0);
        get_b("decerr", 4'd0, 2'b11);
        mem_chk("decerr_mem", 8'd0, 32'hCAFEF00D);

        send_aw(4'd5, 32'h40, 4'd0, 3'd2, 2'b01);
        send_w(4'd6, 32'h1, 4'hF, 1'b1, 0);
        get_b("wid", 4'd5, 2'b10);

        send_aw(4'd7, 32'h50, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(4'd7, 32'hE0 + i, 4'hF, (i == 1) || (i == 3), 0);
        chk("early_last_wready", wready, 0);
        get_b("early_last", 4'd7, 2'b10);

        send_aw(4'd1, 32'h0, 4'd0, 3'd3, 2'b01);
        send_w(4'd1, 32'h12345678, 4'hF, 1'b1, 0);
        get_b("bad_size", 4'd1, 2'b10);
        mem_chk("bad_size_mem", 8'd0, 32'hCAFEF00D);

        send_aw(4'd1, 32'h0, 4'd2, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) send_w(4'd1, 32'h9 + i, 4'hF, i == 2, 0);
        get_b("bad_wrap", 4'd1, 2'b10);
        mem_chk("bad_wrap_mem", 8'd0, 32'hCAFEF00D);

        // 5: B backpressure and W gaps
        send_aw(4'd4, 32'h80, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(4'd4, 32'hB0 + i, 4'hF, i == 3, int'($urandom_range(0, 3)));
        begin
            logic ok = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge aclk);
                if (bvalid) begin ok = 1'b1; break; end
            end
            chk("bp_bvalid_seen", ok, 1);
        end
        for (int c = 0; c < 5; c++) begin
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bid", bid, 4);
            chk("bp_bresp", bresp, 0);
            chk("bp_awready", awready, 0);
            @(negedge aclk);
        end
        bready = 1'b1;
        @(posedge aclk); #1 bready = 1'b0;
        chk("bp_awready_after", awready, 1);
        chk("bp_bvalid_after", bvalid, 0);
        for (int i = 0; i < 4; i++) mem_chk("gap_mem", 8'(32 + i), 32'hB0 + i);

        // 6: reset mid-burst
        send_aw(4'd9, 32'h100, 4'd7, 3'd2, 2'b01);
        send_w(4'd9, 32'hC0, 4'hF, 1'b0, 0);
        send_w(4'd9, 32'hC1, 4'hF, 1'b0, 0);
        @(negedge aclk) arstn = 1'b0;
        @(posedge aclk); #1;
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_wready", wready, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        @(negedge aclk) arstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            chk("mid_rst_no_b", bvalid, 0);
        end
        mem_chk("mid_rst_w64", 8'd64, 32'hC0);
        mem_chk("mid_rst_w65", 8'd65, 32'hC1);
        send_aw(4'd2, 32'h140, 4'd0, 3'd2, 2'b01);
        send_w(4'd2, 32'h77, 4'hF, 1'b1, 0);
        get_b("post_rst", 4'd2, 2'b00);
        mem_chk("post_rst_mem", 8'd80, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
